spw_babasu_time_in_tx: RTL and testbench
========================================

# spw_babasu_time_in_tx

Avalon-MM slave that lets the Nios II host inject SpaceWire time-codes into the link core's TIME_IN/TICK_IN side. It is the transmit-direction counterpart of the read-only TIME_OUT capture port. The block holds a time-code register, queues one tick request, and issues a single-cycle `tick_in` pulse when the link is running. It also offers auto-increment of the 6-bit time value, a programmable periodic tick generator, and an overrun counter.

## Interface
- `PERIOD_W`, 24: width of the periodic-tick divider register.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 2: Avalon word address.
- `chipselect` input 1: Avalon slave select.
- `write_n` input 1: active-low write strobe; a write is valid when `chipselect` is 1 and `write_n` is 0.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data with 1-cycle latency.
- `link_running` input 1: SpaceWire link in Run state.
- `tick_in` output 1: one-cycle time-code send strobe to the link core.
- `time_in` output 6: time value.
- `ctrl_in` output 2: time-code control flags.

## Operation
Register map:
- Address 0, TIME.
  - Write: `time_in` ← wd[5:0], `ctrl_in` ← wd[7:6], and raise a request.
  - Read: {24'b0, ctrl_in, time_in}.
- Address 1, CTRL.
  - Write: bit0 `auto_inc`, bit1 `periodic_en`. Bit2 = 1 clears `overrun_cnt`; it is self-clearing and reads 0.
  - Read: bit0 `auto_inc`, bit1 `periodic_en`, bit8 `pending`, bits[23:16] `overrun_cnt`, all others 0.
- Address 2, PERIOD.
  - Read/write: wd[PERIOD_W-1:0] is the period in clocks.
  - PERIOD = 0 disables periodic ticks.
- Address 3: reads 0; writes are ignored.

Request sources and the pending flag:
- A request comes from either a write to TIME or periodic-timer expiry.
- Coincident requests in the same cycle merge into one request with no overrun.
- A request while `pending` is already 1 increments `overrun_cnt`, which saturates at 255. `pending` stays 1.
- The request payload is the current `time_in`/`ctrl_in` at issue time.

Issue:
- When `pending` = 1 and `link_running` = 1, the block drives `tick_in` = 1 for exactly one cycle and clears `pending`.
- If `link_running` = 0, the request stays pending indefinitely.

Auto-increment:
- When `auto_inc` = 1, `time_in` ← (`time_in` + 1) mod 64 in the cycle after the `tick_in` pulse.
- `ctrl_in` is unchanged.
- A TIME write in that same cycle takes priority over the increment.

Periodic timer:
- The down-counter loads PERIOD-1.
- When it reaches 0 with `periodic_en` = 1 and PERIOD ≠ 0, it raises a request and reloads.
- Writing PERIOD, or writing CTRL with `periodic_en` = 0, reloads the counter.

TIME write during issue:
- A TIME write in the same cycle as an issuing `tick_in` is not an overrun.
- The pulse carries the old value.
- The new write sets `pending` again.

Readdata: updated every clock from the address mux, regardless of `chipselect`.

Reset values (asynchronous):
- Outputs: `readdata` = 0, `tick_in` = 0, `time_in` = 0, `ctrl_in` = 0.
- Internal state: `pending` = 0, `overrun_cnt` = 0, `auto_inc` = 0, `periodic_en` = 0, PERIOD = 0, counter = 0.
- Reset mid-pulse drops `tick_in` immediately and discards any pending request.

## Timing
- Write at edge E0 → `pending` = 1 after E0.
- If `link_running` = 1 at E1 → `tick_in` = 1 from E1 to E2, and `pending` = 0 after E1.
- `time_in`/`ctrl_in` are stable throughout the `tick_in` cycle; they change only on a TIME write or an auto-increment.
- Auto-incremented value is visible after E2.
- Read: `address` sampled at edge E → `readdata` valid after E, so 1-cycle latency.
- Periodic: with PERIOD = P and the link running, `tick_in` pulses every P clocks; the first pulse is P+1 clocks after enable.
- Minimum spacing between `tick_in` pulses: 2 clocks.

## Test plan
- Reset mid-operation: load PERIOD = 4, set periodic_en, assert `reset_n` = 0 with `tick_in` high → `tick_in` drops at once; all registers are 0 after release.
- Link down then up: `link_running` = 0, write TIME = 0x45 → no tick, CTRL bit8 = 1. Raise `link_running` → one pulse with `time_in` = 5, `ctrl_in` = 1; bit8 = 0 afterwards.
- Auto-increment wrap: `auto_inc` = 1, TIME = 0x3F, link up → pulse with `time_in` = 63, then `time_in` = 0. Second write → pulse with `time_in` = 0x3F.
- Periodic tick: PERIOD = 10, `periodic_en` = 1, `auto_inc` = 1, link up for 100 clocks → 9–10 pulses, exactly 10 clocks apart, with `time_in` incrementing by 1 each pulse.
- Overrun: link down, write TIME three times, then read CTRL → `overrun_cnt` = 2. 300 further writes → `overrun_cnt` = 255. CTRL write bit2 → `overrun_cnt` = 0.
- Simultaneous events: TIME write coincident with an issuing pulse → pulse carries the old value, `pending` = 1 afterwards, `overrun_cnt` unchanged. TIME write on the expiry cycle → single pulse, no overrun.

Source files
------------

// File: rtl/spw_babasu_time_in_tx.sv
// Avalon-MM slave that injects SpaceWire time-codes into the link core TICK_IN/TIME_IN side.
// Holds one pending request, issues single-cycle tick_in pulses, with auto-increment, periodic timer and overrun count.
module spw_babasu_time_in_tx #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        link_running,
  output logic        tick_in,
  output logic [5:0]  time_in,
  output logic [1:0]  ctrl_in
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 6;
  localparam int unsigned CW = 2;
  localparam int unsigned OW = 8;
  localparam logic [1:0]    ADDR_TIME   = 2'd0;
  localparam logic [1:0]    ADDR_CTRL   = 2'd1;
  localparam logic [1:0]    ADDR_PERIOD = 2'd2;
  localparam logic [OW-1:0] OVR_MAX     = '1;

  logic                pending;
  logic                auto_inc;
  logic                periodic_en;
  logic [OW-1:0]       overrun_cnt;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;

  logic                pending_nx;
  logic                auto_inc_nx;
  logic                periodic_en_nx;
  logic [OW-1:0]       overrun_nx;
  logic [PERIOD_W-1:0] period_nx;
  logic [PERIOD_W-1:0] cnt_nx;
  logic [TW-1:0]       time_nx;
  logic [CW-1:0]       ctrl_nx;
  logic                tick_nx;
  logic [DW-1:0]       rd_nx;

  logic                wr;
  logic                wr_time;
  logic                wr_ctrl;
  logic                wr_period;
  logic                timer_on;
  logic                expiry;
  logic                req;
  logic                issue;
  logic [PERIOD_W-1:0] wd_period;
  logic [PERIOD_W-1:0] reload_cur;
  logic [PERIOD_W-1:0] reload_wd;

  if (PERIOD_W < DW) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^writedata[DW-1:PERIOD_W];
  end

  // Request sources, issue decision and timer reload values
  always_comb begin
    wr         = chipselect & ~write_n;
    wr_time    = wr & (address == ADDR_TIME);
    wr_ctrl    = wr & (address == ADDR_CTRL);
    wr_period  = wr & (address == ADDR_PERIOD);
    wd_period  = writedata[PERIOD_W-1:0];
    timer_on   = periodic_en & (period != '0);
    expiry     = timer_on & (cnt == '0);
    req        = wr_time | expiry;
    // tick_in gating keeps at least one idle cycle between pulses
    issue      = pending & link_running & ~tick_in;
    reload_cur = (period == '0) ? '0 : period - PERIOD_W'(1);
    reload_wd  = (wd_period == '0) ? '0 : wd_period - PERIOD_W'(1);
  end

  // Next-state for all registers
  always_comb begin
    pending_nx     = pending;
    auto_inc_nx    = auto_inc;
    periodic_en_nx = periodic_en;
    overrun_nx     = overrun_cnt;
    period_nx      = period;
    cnt_nx         = cnt;
    time_nx        = time_in;
    ctrl_nx        = ctrl_in;
    tick_nx        = issue;
    rd_nx          = '0;

    // A request arriving while one is being issued re-arms without counting an overrun
    if (issue) begin
      pending_nx = req;
    end else if (req) begin
      pending_nx = 1'b1;
      if (pending && (overrun_cnt != OVR_MAX)) begin
        overrun_nx = overrun_cnt + OW'(1);
      end
    end

    if (wr_time) begin
      time_nx = writedata[TW-1:0];
      ctrl_nx = writedata[TW+CW-1:TW];
    end else if (tick_in && auto_inc) begin
      time_nx = time_in + TW'(1);
    end

    if (wr_ctrl) begin
      auto_inc_nx    = writedata[0];
      periodic_en_nx = writedata[1];
      if (writedata[2]) begin
        overrun_nx = '0;
      end
    end

    if (wr_period) begin
      period_nx = wd_period;
    end

    // Counter idles at PERIOD-1 while the timer is off so enable starts a full period
    if (wr_period) begin
      cnt_nx = reload_wd;
    end else if (!timer_on || expiry || (wr_ctrl && !writedata[1])) begin
      cnt_nx = reload_cur;
    end else begin
      cnt_nx = cnt - PERIOD_W'(1);
    end

    case (address)
      ADDR_TIME:   rd_nx = DW'({ctrl_in, time_in});
      ADDR_CTRL:   rd_nx = {8'h00, overrun_cnt, 7'h00, pending, 6'h00, periodic_en, auto_inc};
      ADDR_PERIOD: rd_nx = DW'(period);
      default:     rd_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      auto_inc    <= 1'b0;
      periodic_en <= 1'b0;
      overrun_cnt <= '0;
      period      <= '0;
      cnt         <= '0;
      time_in     <= '0;
      ctrl_in     <= '0;
      tick_in     <= 1'b0;
      readdata    <= '0;
    end else begin
      pending     <= pending_nx;
      auto_inc    <= auto_inc_nx;
      periodic_en <= periodic_en_nx;
      overrun_cnt <= overrun_nx;
      period      <= period_nx;
      cnt         <= cnt_nx;
      time_in     <= time_nx;
      ctrl_in     <= ctrl_nx;
      tick_in     <= tick_nx;
      readdata    <= rd_nx;
    end
  end

endmodule

// File: tb/tb_spw_babasu_time_in_tx.sv
// Bench for spw_babasu_time_in_tx: directed scenarios plus random traffic, every edge checked
// against an event-level model (pending flag, overrun count, scheduled timer expiries).
module tb_spw_babasu_time_in_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        link_running;
  logic        tick_in;
  logic [5:0]  time_in;
  logic [1:0]  ctrl_in;

  always #5 clk = ~clk;

  spw_babasu_time_in_tx #(.PERIOD_W(24)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .link_running (link_running),
    .tick_in      (tick_in),
    .time_in      (time_in),
    .ctrl_in      (ctrl_in)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int cyc = 0;
  int m_time, m_ctrl, m_period, m_ovr, last_pulse, next_exp;
  bit m_pending, m_auto, m_en;

  // Observed pulses
  int         pulses;
  logic [5:0] pulse_time;
  logic [1:0] pulse_ctrl;
  int         pcyc[$];
  int         ptime[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0; m_ctrl = 0; m_period = 0; m_ovr = 0;
    m_pending = 0; m_auto = 0; m_en = 0;
    last_pulse = -100; next_exp = -1;
  endtask

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, 2'(m_ctrl), 6'(m_time)};
      2'd1:    return {8'h0, 8'(m_ovr), 7'h0, m_pending, 6'h0, m_en, m_auto};
      2'd2:    return 32'(m_period);
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge: apply the rules to the model, then compare every output
  task automatic step();
    logic [31:0] exp_rd;
    bit wr, wr_time, expiry, req, pulse;
    @(posedge clk);
    cyc++;
    exp_rd  = model_rd(address);
    wr      = chipselect && !write_n;
    wr_time = wr && (address == 2'd0);
    expiry  = (next_exp == cyc);
    req     = wr_time || expiry;
    pulse   = m_pending && link_running && (cyc - last_pulse >= 2);
    if (req && m_pending && !pulse && m_ovr < 255) m_ovr++;
    m_pending = pulse ? req : (m_pending || req);
    if (wr_time) begin
      m_time = int'(writedata[5:0]);
      m_ctrl = int'(writedata[7:6]);
    end else if (m_auto && last_pulse == cyc - 1) begin
      m_time = (m_time + 1) % 64;
    end
    if (expiry) next_exp = cyc + m_period;
    if (wr && address == 2'd1) begin
      m_auto = writedata[0];
      if (writedata[2]) m_ovr = 0;
      if (!writedata[1]) next_exp = -1;
      else if (!m_en && m_period != 0) next_exp = cyc + m_period;
      m_en = writedata[1];
    end
    if (wr && address == 2'd2) begin
      m_period = int'(writedata[23:0]);
      next_exp = (m_en && m_period != 0) ? cyc + m_period : -1;
    end
    if (pulse) last_pulse = cyc;
    #1;
    chk("tick_in", 32'(tick_in), 32'(pulse));
    chk("time_in", 32'(time_in), 32'(m_time));
    chk("ctrl_in", 32'(ctrl_in), 32'(m_ctrl));
    chk("readdata", readdata, exp_rd);
    if (tick_in) begin
      pulses++;
      pulse_time = time_in;
      pulse_ctrl = ctrl_in;
      pcyc.push_back(cyc);
      ptime.push_back(int'(time_in));
    end
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    step();
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; link_running = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_tick", 32'(tick_in), 32'h0);
    chk("rst_time", 32'(time_in), 32'h0);
    chk("rst_ctrl", 32'(ctrl_in), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // Reset while a periodic pulse is on the wire
    link_running = 1'b1;
    wr(2'd2, 32'd4);
    wr(2'd1, 32'h2);
    for (int i = 0; i < 20 && !tick_in; i++) step();
    chk("rst_wait_tick", 32'(tick_in), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("rst_drop_tick", 32'(tick_in), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) begin reset_n = 1'b1; link_running = 1'b0; end
    rd(2'd0); rd(2'd1);
    chk("rst_ctrl_reg", readdata, 32'h0);
    rd(2'd2);
    chk("rst_period_reg", readdata, 32'h0);
    rd(2'd3);

    // Link down then up
    pulses = 0;
    wr(2'd0, 32'h45);
    idle(3);
    rd(2'd1);
    chk("down_pending", 32'(readdata[8]), 32'h1);
    chk("down_no_tick", 32'(pulses), 32'h0);
    link_running = 1'b1;
    idle(3);
    chk("up_pulses", 32'(pulses), 32'h1);
    chk("up_time", 32'(pulse_time), 32'h5);
    chk("up_ctrl", 32'(pulse_ctrl), 32'h1);
    rd(2'd1);
    chk("up_pending_clr", 32'(readdata[8]), 32'h0);

    // Auto-increment wrap
    wr(2'd1, 32'h1);
    pulses = 0;
    wr(2'd0, 32'h3F);
    idle(3);
    chk("wrap_pulses", 32'(pulses), 32'h1);
    chk("wrap_pulse_time", 32'(pulse_time), 32'h3F);
    chk("wrap_after", 32'(time_in), 32'h0);
    pulses = 0;
    wr(2'd0, 32'h3F);
    idle(3);
    chk("wrap2_pulses", 32'(pulses), 32'h1);
    chk("wrap2_pulse_time", 32'(pulse_time), 32'h3F);

    // Periodic ticks with auto-increment
    wr(2'd2, 32'd10);
    pcyc.delete(); ptime.delete();
    wr(2'd1, 32'h3);
    idle(100);
    chk("per_count_ok", 32'(pcyc.size() >= 9 && pcyc.size() <= 10), 32'h1);
    for (int i = 1; i < pcyc.size(); i++) begin
      chk("per_spacing", 32'(pcyc[i] - pcyc[i-1]), 32'd10);
      chk("per_incr", 32'(ptime[i]), 32'((ptime[i-1] + 1) % 64));
    end
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h0);
    idle(3);

    // Overrun counting, saturation and clear
    link_running = 1'b0;
    wr(2'd1, 32'h4);
    wr(2'd0, 32'h1); wr(2'd0, 32'h2); wr(2'd0, 32'h3);
    rd(2'd1);
    chk("ovr_two", 32'(readdata[23:16]), 32'd2);
    repeat (300) wr(2'd0, $urandom);
    rd(2'd1);
    chk("ovr_sat", 32'(readdata[23:16]), 32'd255);
    wr(2'd1, 32'h4);
    rd(2'd1);
    chk("ovr_clr", 32'(readdata[23:16]), 32'd0);
    chk("ovr_clr_pending", 32'(readdata[8]), 32'h1);
    link_running = 1'b1;
    idle(3);

    // TIME write during the pulse cycle
    wr(2'd0, 32'h11);
    idle(1);
    chk("sim_tick", 32'(tick_in), 32'h1);
    chk("sim_old_val", 32'(time_in), 32'h11);
    wr(2'd0, 32'h22);
    chk("sim_new_val", 32'(time_in), 32'h22);
    rd(2'd1);
    chk("sim_pending", 32'(readdata[8]), 32'h1);
    chk("sim_no_ovr", 32'(readdata[23:16]), 32'd0);
    idle(2);

    // TIME write on the timer expiry edge
    wr(2'd2, 32'd6);
    wr(2'd1, 32'h2);
    for (int i = 0; i < 20 && next_exp != cyc + 1; i++) step();
    n_vec++;
    if (next_exp != cyc + 1) begin
      n_err++;
      $error("FAIL exp_sync observed=%0d expected=%0d", cyc + 1, next_exp);
    end
    pulses = 0;
    wr(2'd0, 32'h2A);
    idle(4);
    chk("exp_single_pulse", 32'(pulses), 32'h1);
    rd(2'd1);
    chk("exp_no_ovr", 32'(readdata[23:16]), 32'd0);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      chipselect   = ($urandom_range(0, 3) != 0);
      write_n      = 1'($urandom_range(0, 1));
      address      = 2'($urandom_range(0, 3));
      writedata    = $urandom;
      if (address == 2'd2) writedata = 32'($urandom_range(0, 12));
      link_running = ($urandom_range(0, 3) != 0);
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
